// File: rtl/wait_timer_arbiter.sv
// Module: wait_timer_arbiter
// Round-robin arbiter that shares a single cycle-delay counter among N_REQ
// paint-engine requesters. The winner gets a registered grant while its wait
// runs and a one-cycle done pulse when its latched terminal count is reached.
// Optional feature macro: WAIT_ABORT_EN. When it is defined, the winner can
// cancel its wait by dropping req; it then gets no done pulse.
module wait_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] term_cnt,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] winner, winner_nxt;
  logic [IDX_W-1:0] pick, rr_adv;
  logic             pick_valid;
  logic [CNT_W-1:0] term, term_nxt, cnt_nxt;
  logic [N_REQ-1:0] grant_nxt, done_nxt;
  logic             busy_nxt;

  // Round-robin scan: the first active request at or after rr_ptr wins
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_w;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    idx_w      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % N_REQ;
      idx_w = IDX_W'(idx);
      if (!pick_valid && req[idx_w]) begin
        pick       = idx_w;
        pick_valid = 1'b1;
      end
    end
    rr_adv = IDX_W'((int'(winner) + 1) % N_REQ);
  end

  // Next-state logic for the wait sequencer and the registered outputs
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    winner_nxt = winner;
    term_nxt   = term;
    cnt_nxt    = cnt;
    grant_nxt  = '0;
    done_nxt   = '0;
    busy_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          winner_nxt = pick;
          term_nxt   = term_cnt[pick*CNT_W +: CNT_W];
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
`ifdef WAIT_ABORT_EN
        if (!req[winner]) begin
          rr_ptr_nxt = rr_adv;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
`else
        cnt_nxt   = '0;
        state_nxt = COUNT;
`endif
      end
      COUNT: begin
`ifdef WAIT_ABORT_EN
        if (!req[winner]) begin
          rr_ptr_nxt = rr_adv;
          state_nxt  = IDLE;
        end else if (cnt == term) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`else
        if (cnt == term) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        rr_ptr_nxt = rr_adv;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        rr_ptr_nxt = '0;
        winner_nxt = '0;
        term_nxt   = '0;
        cnt_nxt    = '0;
      end
    endcase
    if (state_nxt == LOAD || state_nxt == COUNT) begin
      grant_nxt[winner_nxt] = 1'b1;
    end
    if (state_nxt == DONE) begin
      done_nxt[winner_nxt] = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counter and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
      term   <= '0;
      cnt    <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      winner <= winner_nxt;
      term   <= term_nxt;
      cnt    <= cnt_nxt;
      grant  <= grant_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wait_timer_arbiter.sv
// Testbench: tb_wait_timer_arbiter
// Drives random requests, terminal counts and occasional resets into
// wait_timer_arbiter. A transaction-level model predicts each cycle's grant,
// done, busy and cnt from the wait start cycle and the latched terminal count.
module tb_wait_timer_arbiter;

  localparam int N_REQ  = 4;
  localparam int CNT_W  = 24;
  localparam int CYCLES = 6000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] term_cnt;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [CNT_W-1:0]       cnt;

  int checks   = 0;
  int failures = 0;
  int dones    = 0;
  int cyc      = 0;

  bit m_active;
  int m_g;
  int m_term;
  int m_win;
  int m_rr;
  int m_cnt;

  wait_timer_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .term_cnt (term_cnt),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .cnt      (cnt)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int iter);
    rst = (iter < 2) || ($urandom_range(0, 299) == 0);
    for (int i = 0; i < N_REQ; i++) begin
      if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 15) == 0)
          term_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(20, 60));
        else
          term_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 8));
      end
    end
  endtask

  // Compare this cycle's outputs against the wait timeline of the model
  task automatic compareCycle();
    logic [31:0] exp_grant, exp_done, exp_busy, exp_cnt;
    exp_grant = 0;
    exp_done  = 0;
    exp_busy  = 0;
    exp_cnt   = m_cnt;
    if (m_active) begin
      exp_busy = 1;
      if (cyc <= m_g + m_term + 1) begin
        exp_grant = 32'd1 << m_win;
        exp_cnt   = (cyc == m_g) ? m_cnt : cyc - m_g - 1;
      end else begin
        exp_done = 32'd1 << m_win;
        exp_cnt  = m_term;
      end
    end
    checkOutput("grant", 32'(grant), exp_grant);
    checkOutput("done",  32'(done),  exp_done);
    checkOutput("busy",  32'(busy),  exp_busy);
    checkOutput("cnt",   32'(cnt),   exp_cnt);
    if (done != 0) dones++;
  endtask

  // Advance the model using the inputs present during this cycle
  task automatic modelUpdate();
    int idx;
    if (rst) begin
      m_active = 0;
      m_cnt    = 0;
      m_rr     = 0;
    end else if (!m_active) begin
      if (req != 0) begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          idx = (m_rr + k) % N_REQ;
          if (req[idx]) m_win = idx;
        end
        m_term   = int'(term_cnt[m_win*CNT_W +: CNT_W]);
        m_g      = cyc + 1;
        m_active = 1;
      end
    end else if (cyc == m_g + m_term + 2) begin
      m_active = 0;
      m_cnt    = m_term;
      m_rr     = (m_win + 1) % N_REQ;
    end
`ifdef WAIT_ABORT_EN
    else if (!req[m_win]) begin
      if (cyc != m_g) m_cnt = cyc - m_g - 1;
      m_active = 0;
      m_rr     = (m_win + 1) % N_REQ;
    end
`endif
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    term_cnt = '0;
    m_active = 0;
    m_g      = 0;
    m_term   = 0;
    m_win    = 0;
    m_rr     = 0;
    m_cnt    = 0;
    @(posedge clk);
    #1;
    for (int iter = 0; iter < CYCLES; iter++) begin
      @(negedge clk);
      compareCycle();
      modelUpdate();
      @(posedge clk);
      #1;
      applyStimulus(iter);
      cyc++;
    end
    checkOutput("done_seen", 32'(dones > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
